// File: rtl/err_metric_acc.sv
// Error-metric accumulator for an approximate multiplier: collects error count, signed/absolute
// error-distance sums and max error over N samples, then computes MED with a restoring divider.
module err_metric_acc #(
    parameter int W     = 16,
    parameter int N_W   = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     exact,
    input  logic [W-1:0]     apprx,
    output logic             busy,
    output logic             done,
    output logic [N_W-1:0]   err_cnt,
    output logic [ACC_W:0]   sum_ed,
    output logic [ACC_W-1:0] sum_ed_abs,
    output logic [W-1:0]     max_ed,
    output logic [ACC_W-1:0] med,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
    localparam int STEP_W = $clog2(ACC_W + 1);

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d, cnt_q, cnt_d, err_q, err_d;
    logic [ACC_W:0]     sum_ed_q, sum_ed_d;
    logic [ACC_W-1:0]   abs_q, abs_d, med_q, med_d, dvd_q, dvd_d;
    logic [W-1:0]       max_q, max_d;
    logic [N_W-1:0]     rem_q, rem_d;
    logic [STEP_W-1:0]  step_q, step_d;

    // Handshake: a pair transfers on any rising edge where in_valid && in_ready; in_ready is high only in RUN.
    logic           hs;
    logic [W:0]     diff;
    logic [W-1:0]   abs_diff;
    logic [N_W:0]   rem_shift;
    logic [N_W-1:0] rem_sub;
    logic           ge;

    assign hs        = (state_q == S_RUN) && in_valid;
    assign diff      = {1'b0, exact} - {1'b0, apprx};
    assign abs_diff  = diff[W] ? (~diff[W-1:0] + 1'b1) : diff[W-1:0];
    assign rem_shift = {rem_q, dvd_q[ACC_W-1]};
    assign ge        = rem_shift >= {1'b0, n_q};
    // When ge holds the difference is below n_q, so the low N_W bits carry the full remainder.
    assign rem_sub   = rem_shift[N_W-1:0] - n_q;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sum_ed_d = sum_ed_q;
        abs_d    = abs_q;
        max_d    = max_q;
        med_d    = med_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        step_d   = step_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d    = '0;
                    sum_ed_d = '0;
                    abs_d    = '0;
                    max_d    = '0;
                    med_d    = '0;
                    cnt_d    = '0;
                    n_d      = num_samples;
                    state_d  = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (hs) begin
                    sum_ed_d = sum_ed_q + {{(ACC_W-W){diff[W]}}, diff};
                    abs_d    = abs_q + {{(ACC_W-W){1'b0}}, abs_diff};
                    err_d    = err_q + N_W'(diff != '0);
                    max_d    = (abs_diff > max_q) ? abs_diff : max_q;
                    cnt_d    = cnt_q + N_W'(1);
                    if (cnt_d == n_q) begin
                        state_d = S_DIV;
                        dvd_d   = abs_d;
                        rem_d   = '0;
                        step_d  = '0;
                    end
                end
            end
            S_DIV: begin
                rem_d  = ge ? rem_sub : rem_shift[N_W-1:0];
                dvd_d  = {dvd_q[ACC_W-2:0], ge};
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(ACC_W - 1)) begin
                    med_d   = {dvd_q[ACC_W-2:0], ge};
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            sum_ed_q <= '0;
            abs_q    <= '0;
            max_q    <= '0;
            med_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sum_ed_q <= sum_ed_d;
            abs_q    <= abs_d;
            max_q    <= max_d;
            med_q    <= med_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            step_q   <= step_d;
        end
    end

    assign in_ready   = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN) || (state_q == S_DIV);
    assign done       = (state_q == S_DONE);
    assign err_cnt    = err_q;
    assign sum_ed     = sum_ed_q;
    assign sum_ed_abs = abs_q;
    assign max_ed     = max_q;
    assign med        = med_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_err_metric_acc.sv
// Self-checking bench for err_metric_acc: randomized and directed runs, expected statistics
// pushed per run into a queue and popped by a monitor on each rising edge of done.
module tb_err_metric_acc;

    localparam int W = 16;
    localparam int N_W = 16;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [N_W-1:0]   num_samples = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     exact = '0;
    logic [W-1:0]     apprx = '0;
    logic             busy;
    logic             done;
    logic [N_W-1:0]   err_cnt;
    logic [ACC_W:0]   sum_ed;
    logic [ACC_W-1:0] sum_ed_abs;
    logic [W-1:0]     max_ed;
    logic [ACC_W-1:0] med;
    logic [1:0]       dbg_state;

    err_metric_acc #(.W(W), .N_W(N_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .apprx(apprx),
        .busy(busy), .done(done), .err_cnt(err_cnt), .sum_ed(sum_ed),
        .sum_ed_abs(sum_ed_abs), .max_ed(max_ed), .med(med), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        longint err;
        longint sed;
        longint sabs;
        longint mx;
        longint med;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   last_exp;
    int     pe_q[$];
    int     pa_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;
    longint last_hs = 0;
    logic   done_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_stats(input string tag, input exp_t e);
        check({tag, "_err_cnt"}, longint'(err_cnt), e.err);
        check({tag, "_sum_ed"}, longint'($signed(sum_ed)), e.sed);
        check({tag, "_sum_ed_abs"}, longint'(sum_ed_abs), e.sabs);
        check({tag, "_max_ed"}, longint'(max_ed), e.mx);
        check({tag, "_med"}, longint'(med), e.med);
    endtask

    // reference model: statistics straight from the pair lists
    function automatic exp_t model(input int n);
        exp_t   e;
        longint d;
        e = '{0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) begin
            d = longint'(pe_q[i]) - longint'(pa_q[i]);
            e.sed += d;
            if (d < 0) d = -d;
            e.sabs += d;
            if (d != 0) e.err++;
            if (d > e.mx) e.mx = d;
        end
        e.med = (n > 0) ? e.sabs / n : 0;
        return e;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (in_valid && in_ready) last_hs = cyc;
        if (done && !done_prev) begin
            check("exp_q_nonempty", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_stats("mon", e);
                check("busy_at_done", longint'(busy), 0);
                check("done_latency", cyc - last_hs, 33);
            end
        end
        done_prev = done;
    end

    // driver tasks (all entered and left at 1 time unit after a rising edge)
    task automatic do_start(input int n);
        start = 1'b1;
        num_samples = N_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        num_samples = N_W'($urandom);
    endtask

    task automatic send(input int e, input int a);
        bit ok = 1'b0;
        exact = W'(e);
        apprx = W'(a);
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("handshake_ready", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exact = W'($urandom);
        apprx = W'($urandom);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", longint'(ok), 1);
        @(posedge clk); #1;
    endtask

    // gap: idle cycle after each pair; start_at: pulse start in RUN before that pair index
    task automatic run_list(input int n, input bit push, input bit gap, input int start_at);
        exp_t e;
        e = model(n);
        if (push) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        do_start(n);
        for (int i = 0; i < n; i++) begin
            if (i == start_at) do_start(1);
            send(pe_q[i], pa_q[i]);
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic fill_random(input int n);
        int e;
        pe_q.delete();
        pa_q.delete();
        for (int i = 0; i < n; i++) begin
            e = $urandom_range(0, 65535);
            pe_q.push_back(e);
            case ($urandom_range(0, 2))
                0: pa_q.push_back(e);
                1: pa_q.push_back(int'(W'(e ^ $urandom_range(0, 255))));
                default: pa_q.push_back($urandom_range(0, 65535));
            endcase
        end
    endtask

    initial begin
        exp_t z;
        int   n;
        z = '{0, 0, 0, 0, 0};

        // reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            in_valid = 1'($urandom);
            exact = W'($urandom);
            apprx = W'($urandom);
            num_samples = N_W'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_state", longint'(dbg_state), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check_stats("rst", z);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", longint'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // exact match
        pe_q = '{32'h1234, 32'h1234, 32'h1234, 32'h1234};
        pa_q = '{32'h1234, 32'h1234, 32'h1234, 32'h1234};
        run_list(4, 1'b1, 1'b0, -1);
        wait_done();

        // mixed errors
        pe_q = '{100, 50, 7};
        pa_q = '{90, 60, 7};
        run_list(3, 1'b1, 1'b0, -1);
        wait_done();

        // gaps, then extra pairs during DIV and DONE
        pe_q = '{300, 12};
        pa_q = '{1000, 40};
        run_list(2, 1'b1, 1'b1, -1);
        exact = 16'd9999;
        apprx = 16'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("div_state", longint'(dbg_state), 2);
        check("div_in_ready", longint'(in_ready), 0);
        check("div_busy", longint'(busy), 1);
        @(posedge clk); #1;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_stats("hold", last_exp);
        @(posedge clk); #1;

        // start pulsed mid-RUN is ignored
        fill_random(5);
        run_list(5, 1'b1, 1'b0, 2);
        wait_done();

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            fill_random(n);
            run_list(n, 1'b1, ($urandom_range(0, 1) == 1), -1);
            wait_done();
        end

        // N=0 from DONE with nonzero statistics held
        do_start(0);
        @(negedge clk);
        check("n0_done", longint'(done), 1);
        check("n0_busy", longint'(busy), 0);
        check_stats("n0", z);
        @(posedge clk); #1;

        // reset mid-DIV
        fill_random(3);
        pe_q[0] = 500;
        pa_q[0] = 1;
        run_list(3, 1'b0, 1'b0, -1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_div_state", longint'(dbg_state), 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_div_state", longint'(dbg_state), 0);
        check("rst_div_busy", longint'(busy), 0);
        check("rst_div_done", longint'(done), 0);
        check_stats("rst_div", z);
        @(posedge clk); #1;

        // width corner
        pe_q.delete();
        pa_q.delete();
        for (int i = 0; i < 65535; i++) begin
            pe_q.push_back(65535);
            pa_q.push_back(0);
        end
        run_list(65535, 1'b1, 1'b0, -1);
        wait_done();
        @(negedge clk);
        check("wide_sum_ed_abs", longint'(sum_ed_abs), 64'd4294836225);
        check("wide_sum_ed", longint'($signed(sum_ed)), 64'd4294836225);
        check("wide_med", longint'(med), 65535);

        repeat (3) @(posedge clk);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/err_metric_acc.md
# err_metric_acc

Hardware error-metric accumulator placed directly downstream of the approximate 8x8 multiplier under test and its exact reference product. It consumes one exact/approximate product pair per valid/ready handshake and accumulates the statistics the team tracks: error count, signed and absolute error-distance sums, and maximum absolute error distance. After a programmed number of samples it computes MED (mean absolute error distance) with a sequential restoring divider, then raises `done`. This moves MED/ER extraction from simulation-only real arithmetic into synthesizable, cycle-accurate logic usable on silicon or FPGA.

## Interface
- `W`, 16, product width (exact and approximate).
- `N_W`, 16, sample-counter width.
- `ACC_W`, 32, absolute-sum and MED width; must satisfy ACC_W >= W + N_W.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse; clears accumulators and latches `num_samples`.
- `num_samples`  in  N_W  number of pairs to accumulate; sampled on `start`.
- `in_valid`  in  1  `exact`/`apprx` pair valid.
- `in_ready`  out  1  block accepts a pair this cycle.
- `exact`  in  W  exact product, unsigned.
- `apprx`  in  W  approximate product, unsigned.
- `busy`  out  1  high in RUN or DIV.
- `done`  out  1  high in DONE; held until the next accepted `start` or reset.
- `err_cnt`  out  N_W  pairs with exact != apprx.
- `sum_ed`  out  ACC_W+1  signed two's-complement sum of (exact - apprx).
- `sum_ed_abs`  out  ACC_W  sum of |exact - apprx|.
- `max_ed`  out  W  maximum |exact - apprx| seen.
- `med`  out  ACC_W  floor(sum_ed_abs / num_samples); valid while `done`=1.

## Operation
- States: IDLE, RUN, DIV, DONE. Reset value is IDLE; every output register is 0 and `in_ready`=`busy`=`done`=0.
- IDLE/DONE + `start`=1:
  - If `num_samples`=0: go to DONE; all statistics 0; `med`=0.
  - Otherwise: go to RUN; clear `err_cnt`, `sum_ed`, `sum_ed_abs`, `max_ed`, `med`, and the sample counter; latch `num_samples`.
- `start` in RUN or DIV is ignored.
- RUN: `in_ready`=1. Handshake = `in_valid` && `in_ready`. On each handshake:
  - d = exact - apprx, computed at W+1 signed.
  - |d| is W bits unsigned.
  - `sum_ed` += sign-extended d; `sum_ed_abs` += |d|.
  - `err_cnt` += (d != 0); `max_ed` = max(`max_ed`, |d|); sample counter += 1.
- A handshake that brings the counter to `num_samples` moves the block to DIV.
- `in_valid` without `in_ready` (IDLE, DIV, DONE) has no effect.
- DIV: `in_ready`=0. Restoring division of `sum_ed_abs` by the latched N, one quotient bit per cycle, MSB first, ACC_W iterations. The result is written to `med`, then the block goes to DONE.
- DONE: all statistics are held stable.
- Width rules:
  - ACC_W >= W + N_W guarantees no overflow of `sum_ed_abs`.
  - ACC_W+1 guarantees no overflow of `sum_ed`.
  - Neither accumulator saturates or wraps.

## Timing
- Accumulator outputs reflect a handshake after the same rising edge that accepts it: one cycle of latency, no bypass.
- `start` at edge k: state RUN after edge k, so `in_ready`=1 in the cycle after the `start` cycle.
- Last handshake at edge k: state DIV after edge k. Division steps occur on edges k+1..k+ACC_W. `med` is valid and `done`=1 after edge k+ACC_W.
- `rst_n`=0 at any edge, including mid-RUN or mid-DIV: the block returns to the reset values above at that edge. No partial results are retained.
- `start` and a handshake in the same cycle are impossible: `in_ready`=0 in the states where `start` is honoured.

## Test plan
- Reset: hold `rst_n`=0 for 3 edges with random inputs. Required: all outputs 0, state IDLE; after release, `in_ready`=0 until `start`.
- Exact match: `start`, N=4, four pairs exact=apprx=0x1234. Required: `err_cnt`=0, `sum_ed`=0, `sum_ed_abs`=0, `max_ed`=0; `done`=1 and `med`=0 exactly 32 edges after the 4th handshake.
- Mixed errors: N=3, pairs (100,90), (50,60), (7,7). Required: `err_cnt`=2, `sum_ed`=0, `sum_ed_abs`=20, `max_ed`=10, `med`=6.
- Handshake gaps: N=2, `in_valid` toggled every other cycle; an extra pair is driven during DIV and DONE. Required: only 2 handshakes are counted; the extra pair changes nothing.
- Width corner: N=65535, every pair (65535,0). Required: `sum_ed_abs`=4294836225, `sum_ed`=+4294836225, `max_ed`=65535, `med`=65535, no wrap.
- Control corners:
  - `start` pulsed mid-RUN: ignored; the count continues.
  - `rst_n` low mid-DIV: all outputs return to 0.
  - `start` with N=0: `done`=1 one edge later with all statistics 0.
